freq_sweep_sequencer: RTL and testbench

- Generates the 8-bit `freq_param` code for the frequency-programmable clock generator.
- Steps the code from a start value to a stop value and holds each code for a programmable number of cycles (the dwell).
- Sweep modes: single ramp, repeating ramp and triangle.
- Sits between the control/UI logic and the clock generator; runs on the same 1 MHz clock the generator uses as input.

---
 rtl/freq_sweep_sequencer_pkg.sv | 17 +
 rtl/freq_sweep_sequencer_sweep_step_calc.sv | 41 ++++
 rtl/freq_sweep_sequencer.sv | 163 ++++++++++++++++
 tb/tb_freq_sweep_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_sweep_sequencer_pkg.sv
// Shared definitions for the frequency sweep sequencer: mode encodings,
// FSM state type and default widths.
package freq_sweep_sequencer_pkg;

  localparam int DEF_CODE_W  = 8;
  localparam int DEF_DWELL_W = 20;

  localparam logic [1:0] MODE_RAMP   = 2'd0;
  localparam logic [1:0] MODE_REPEAT = 2'd1;
  localparam logic [1:0] MODE_TRI    = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/freq_sweep_sequencer_sweep_step_calc.sv
// Combinational next-code calculator: steps current toward target by step,
// clamping at the target, using one extra bit so nothing wraps.
module sweep_step_calc
  import freq_sweep_sequencer_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic [CODE_W-1:0] current,
  input  logic [CODE_W-1:0] target,
  input  logic [CODE_W-1:0] step,
  input  logic              dir_up,
  output logic [CODE_W-1:0] next_code,
  output logic              at_target
);

  logic [CODE_W:0] sum_s;
  logic [CODE_W:0] diff_s;

  // Clamped step toward the target; a borrow out of diff means underflow.
  always_comb begin
    sum_s     = {1'b0, current} + {1'b0, step};
    diff_s    = {1'b0, current} - {1'b0, step};
    at_target = (current == target);
    if (at_target) begin
      next_code = target;
    end else if (dir_up) begin
      if (sum_s >= {1'b0, target}) begin
        next_code = target;
      end else begin
        next_code = sum_s[CODE_W-1:0];
      end
    end else begin
      if (diff_s[CODE_W] || (diff_s <= {1'b0, target})) begin
        next_code = target;
      end else begin
        next_code = diff_s[CODE_W-1:0];
      end
    end
  end

endmodule

// File: rtl/freq_sweep_sequencer.sv
// Frequency code sweep sequencer: ramps freq_param from a start code to a
// stop code, holding each code for a programmable dwell.
module freq_sweep_sequencer
  import freq_sweep_sequencer_pkg::*;
#(
  parameter int CODE_W  = DEF_CODE_W,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [CODE_W-1:0]  code_start,
  input  logic [CODE_W-1:0]  code_stop,
  input  logic [CODE_W-1:0]  step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [CODE_W-1:0]  freq_param,
  output logic               busy,
  output logic               step_strobe,
  output logic               done
);

  localparam logic [CODE_W-1:0]  CODE_ONE   = CODE_W'(1);
  localparam logic [CODE_W-1:0]  CODE_ZERO  = {CODE_W{1'b0}};
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};

  state_t              state_r;
  logic [1:0]          mode_r;
  logic [CODE_W-1:0]   start_r;
  logic [CODE_W-1:0]   stop_r;
  logic [CODE_W-1:0]   step_r;
  logic [CODE_W-1:0]   target_r;
  logic                dir_up_r;
  logic [DWELL_W-1:0]  dwell_m1_r;
  logic [DWELL_W-1:0]  cnt_r;

  logic [CODE_W-1:0]   step_norm_s;
  logic [DWELL_W-1:0]  dwell_m1_s;
  logic [CODE_W-1:0]   other_target_s;
  logic [CODE_W-1:0]   fwd_next_s;
  logic                fwd_at_target_s;
  logic [CODE_W-1:0]   rev_next_s;
  logic                rev_at_target_s;

  // Input normalisation and the opposite triangle endpoint.
  always_comb begin
    if (step == CODE_ZERO) begin
      step_norm_s = CODE_ONE;
    end else begin
      step_norm_s = step;
    end
    if (dwell == DWELL_ZERO) begin
      dwell_m1_s = DWELL_ZERO;
    end else begin
      dwell_m1_s = dwell - DWELL_ONE;
    end
    if (target_r == stop_r) begin
      other_target_s = start_r;
    end else begin
      other_target_s = stop_r;
    end
  end

  sweep_step_calc #(.CODE_W(CODE_W)) u_fwd_calc (
    .current   (freq_param),
    .target    (target_r),
    .step      (step_r),
    .dir_up    (dir_up_r),
    .next_code (fwd_next_s),
    .at_target (fwd_at_target_s)
  );

  // Triangle turnaround: step away from the reached endpoint immediately.
  sweep_step_calc #(.CODE_W(CODE_W)) u_rev_calc (
    .current   (freq_param),
    .target    (other_target_s),
    .step      (step_r),
    .dir_up    (~dir_up_r),
    .next_code (rev_next_s),
    .at_target (rev_at_target_s)
  );

  // Sweep FSM with dwell counter and registered outputs.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_r     <= IDLE;
      mode_r      <= MODE_RAMP;
      start_r     <= CODE_ZERO;
      stop_r      <= CODE_ZERO;
      step_r      <= CODE_ONE;
      target_r    <= CODE_ZERO;
      dir_up_r    <= 1'b1;
      dwell_m1_r  <= DWELL_ZERO;
      cnt_r       <= DWELL_ZERO;
      freq_param  <= CODE_ZERO;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !abort) begin
            mode_r      <= (mode == 2'd3) ? MODE_RAMP : mode;
            start_r     <= code_start;
            stop_r      <= code_stop;
            step_r      <= step_norm_s;
            target_r    <= code_stop;
            dir_up_r    <= (code_stop >= code_start);
            dwell_m1_r  <= dwell_m1_s;
            cnt_r       <= dwell_m1_s;
            freq_param  <= code_start;
            step_strobe <= 1'b1;
            busy        <= 1'b1;
            state_r     <= RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_r != DWELL_ZERO) begin
            cnt_r <= cnt_r - DWELL_ONE;
          end else begin
            cnt_r <= dwell_m1_r;
            if (!fwd_at_target_s) begin
              freq_param  <= fwd_next_s;
              step_strobe <= 1'b1;
            end else begin
              case (mode_r)
                MODE_REPEAT: begin
                  freq_param  <= start_r;
                  step_strobe <= (start_r != freq_param);
                end
                MODE_TRI: begin
                  freq_param  <= rev_next_s;
                  step_strobe <= ~rev_at_target_s;
                  target_r    <= other_target_s;
                  dir_up_r    <= ~dir_up_r;
                end
                default: begin
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= IDLE;
                end
              endcase
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_sweep_sequencer.sv
// Directed self-checking bench for freq_sweep_sequencer.
module tb_freq_sweep_sequencer;

  logic        clk_in = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  code_start = 8'd0;
  logic [7:0]  code_stop = 8'd0;
  logic [7:0]  step = 8'd0;
  logic [19:0] dwell = 20'd0;
  logic [7:0]  freq_param;
  logic        busy;
  logic        step_strobe;
  logic        done;

  int checks = 0;
  int errors = 0;

  freq_sweep_sequencer dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .code_start  (code_start),
    .code_stop   (code_stop),
    .step        (step),
    .dwell       (dwell),
    .freq_param  (freq_param),
    .busy        (busy),
    .step_strobe (step_strobe),
    .done        (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] cs, input logic [7:0] ce,
                        input logic [7:0] st, input logic [19:0] dw);
    mode = m; code_start = cs; code_stop = ce; step = st; dwell = dw;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (freq_param !== 8'd0 || busy !== 1'b0 || step_strobe !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset got f=%0d b=%0b s=%0b d=%0b want 0 0 0 0", freq_param, busy, step_strobe, done);
    end
  endtask

  task automatic test_ramp_up();
    logic [7:0] exp_f [14];
    int strobes;
    exp_f = '{8'd10, 8'd10, 8'd10, 8'd20, 8'd20, 8'd20, 8'd30, 8'd30, 8'd30,
              8'd40, 8'd40, 8'd40, 8'd40, 8'd40};
    strobes = 0;
    launch(2'd0, 8'd10, 8'd40, 8'd10, 20'd3);
    for (int k = 0; k < 14; k++) begin
      if (k > 0) cyc();
      if (step_strobe === 1'b1) strobes++;
      checks++;
      if (freq_param !== exp_f[k]) begin
        errors++; $display("FAIL ramp_up_freq k=%0d got %0d want %0d", k, freq_param, exp_f[k]);
      end
      checks++;
      if (step_strobe !== ((k % 3 == 0) && k < 12)) begin
        errors++; $display("FAIL ramp_up_strobe k=%0d got %0b", k, step_strobe);
      end
      checks++;
      if (done !== (k == 12) || busy !== (k < 12)) begin
        errors++; $display("FAIL ramp_up_done_busy k=%0d got d=%0b b=%0b", k, done, busy);
      end
    end
    checks++;
    if (strobes != 4) begin
      errors++; $display("FAIL ramp_up_strobe_count got %0d want 4", strobes);
    end
  endtask

  task automatic test_clamp_down();
    logic [7:0] exp_f [6];
    exp_f = '{8'd35, 8'd25, 8'd15, 8'd5, 8'd5, 8'd5};
    launch(2'd0, 8'd35, 8'd5, 8'd10, 20'd1);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      checks++;
      if (freq_param !== exp_f[k]) begin
        errors++; $display("FAIL clamp_down_freq k=%0d got %0d want %0d", k, freq_param, exp_f[k]);
      end
      checks++;
      if (step_strobe !== (k < 4) || done !== (k == 4) || busy !== (k < 4)) begin
        errors++; $display("FAIL clamp_down_flags k=%0d got s=%0b d=%0b b=%0b", k, step_strobe, done, busy);
      end
    end
  endtask

  task automatic test_triangle();
    logic [7:0] exp_f [8];
    exp_f = '{8'd100, 8'd90, 8'd80, 8'd90, 8'd100, 8'd90, 8'd80, 8'd90};
    launch(2'd2, 8'd100, 8'd80, 8'd10, 20'd0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      checks++;
      if (freq_param !== exp_f[k]) begin
        errors++; $display("FAIL triangle_freq k=%0d got %0d want %0d", k, freq_param, exp_f[k]);
      end
      checks++;
      if (step_strobe !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL triangle_flags k=%0d got s=%0b d=%0b b=%0b", k, step_strobe, done, busy);
      end
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || freq_param !== 8'd90 || done !== 1'b0) begin
      errors++; $display("FAIL triangle_abort got b=%0b f=%0d d=%0b want 0 90 0", busy, freq_param, done);
    end
  endtask

  task automatic test_repeat_abort();
    logic [7:0] exp_f [9];
    exp_f = '{8'd0, 8'd0, 8'd128, 8'd128, 8'd255, 8'd255, 8'd0, 8'd0, 8'd128};
    launch(2'd1, 8'd0, 8'd255, 8'd128, 20'd2);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) cyc();
      checks++;
      if (freq_param !== exp_f[k] || step_strobe !== (k % 2 == 0)) begin
        errors++; $display("FAIL repeat_seq k=%0d got f=%0d s=%0b want f=%0d", k, freq_param, step_strobe, exp_f[k]);
      end
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      checks++;
      if (busy !== 1'b0 || freq_param !== 8'd128 || done !== 1'b0 || step_strobe !== 1'b0) begin
        errors++; $display("FAIL repeat_abort k=%0d got b=%0b f=%0d d=%0b s=%0b", k, busy, freq_param, done, step_strobe);
      end
    end
  endtask

  task automatic test_back_to_back();
    launch(2'd0, 8'd10, 8'd40, 8'd10, 20'd3);
    cyc();
    mode = 2'd1; code_start = 8'd200; code_stop = 8'd250; step = 8'd1; dwell = 20'd1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (freq_param !== 8'd10 || step_strobe !== 1'b0) begin
      errors++; $display("FAIL busy_start_k2 got f=%0d s=%0b want 10 0", freq_param, step_strobe);
    end
    for (int k = 3; k < 13; k++) begin
      cyc();
      if (k == 3 || k == 9) begin
        checks++;
        if (freq_param !== ((k == 3) ? 8'd20 : 8'd40) || step_strobe !== 1'b1) begin
          errors++; $display("FAIL busy_start_step k=%0d got f=%0d s=%0b", k, freq_param, step_strobe);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || freq_param !== 8'd40) begin
      errors++; $display("FAIL busy_start_done got d=%0b b=%0b f=%0d want 1 0 40", done, busy, freq_param);
    end
  endtask

  task automatic test_abort_on_finish();
    launch(2'd0, 8'd5, 8'd5, 8'd3, 20'd1);
    checks++;
    if (freq_param !== 8'd5 || busy !== 1'b1 || step_strobe !== 1'b1) begin
      errors++; $display("FAIL equal_start got f=%0d b=%0b s=%0b want 5 1 1", freq_param, busy, step_strobe);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || freq_param !== 8'd5) begin
      errors++; $display("FAIL abort_on_finish got d=%0b b=%0b f=%0d want 0 0 5", done, busy, freq_param);
    end
  endtask

  task automatic test_equal_hold();
    launch(2'd2, 8'd7, 8'd7, 8'd1, 20'd1);
    for (int k = 1; k < 6; k++) begin
      cyc();
      checks++;
      if (freq_param !== 8'd7 || step_strobe !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL equal_hold k=%0d got f=%0d s=%0b b=%0b d=%0b", k, freq_param, step_strobe, busy, done);
      end
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    launch(2'd1, 8'd0, 8'd255, 8'd128, 20'd2);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++;
    if (freq_param !== 8'd0 || busy !== 1'b0 || step_strobe !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_mid got f=%0d b=%0b s=%0b d=%0b", freq_param, busy, step_strobe, done);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || step_strobe !== 1'b0 || freq_param !== 8'd0) begin
      errors++; $display("FAIL reset_mid_after got b=%0b s=%0b f=%0d", busy, step_strobe, freq_param);
    end
    mode = 2'd0; code_start = 8'd50; code_stop = 8'd60; step = 8'd1; dwell = 20'd1;
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || step_strobe !== 1'b0 || freq_param !== 8'd0) begin
      errors++; $display("FAIL start_abort_idle got b=%0b s=%0b f=%0d want 0 0 0", busy, step_strobe, freq_param);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_ramp_up();
    test_clamp_down();
    test_triangle();
    test_repeat_abort();
    test_back_to_back();
    test_abort_on_finish();
    test_equal_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
